// File: rtl/level_palette_ctrl.sv
// level_palette_ctrl: game-level sequencer for the palette LEVEL select; LEVEL_FLASH_EN adds the level-up flash
module level_palette_ctrl #(
  parameter int LINES_PER_LEVEL = 10,
  parameter int FLASH_FRAMES    = 8
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       game_start_i,
  input  logic       game_over_i,
  input  logic [2:0] start_level_i,
  input  logic       frame_tick_i,
  input  logic       clear_valid_i,
  input  logic [2:0] clear_count_i,
  output logic [2:0] level_o,
  output logic       level_up_o,
  output logic [3:0] line_acc_o,
  output logic [9:0] lines_total_o,
  output logic       flash_active_o,
  output logic       flash_phase_o
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PLAY  = 2'd1;
`ifdef LEVEL_FLASH_EN
  localparam logic [1:0] FLASH = 2'd2;
`endif
  logic [1:0]  state_q, state_d;
  logic [2:0]  level_q, level_d;
  logic [3:0]  acc_q, acc_d;
  logic [9:0]  total_q, total_d;
  logic        up_q, up_d;
  logic [2:0]  cc;
  logic [4:0]  sum;
  logic [10:0] tsum;
  logic        lvl_step;
  assign cc       = (clear_count_i > 3'd4) ? 3'd4 : clear_count_i;
  assign sum      = {1'b0, acc_q} + {2'b0, cc};
  assign tsum     = {1'b0, total_q} + {8'b0, cc};
  assign lvl_step = sum >= 5'(LINES_PER_LEVEL);
`ifdef LEVEL_FLASH_EN
  logic [7:0] fcnt_q, fcnt_d;
  logic       phase_q, phase_d;
  assign flash_active_o = state_q == FLASH;
  assign flash_phase_o  = phase_q;
`else
  logic unused_cfg;
  assign unused_cfg     = frame_tick_i ^ (FLASH_FRAMES == 0);
  assign flash_active_o = 1'b0;
  assign flash_phase_o  = 1'b0;
`endif
  // next-state: start > over > clear > frame tick, lower events dropped
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    acc_d   = acc_q;
    total_d = total_q;
    up_d    = 1'b0;
`ifdef LEVEL_FLASH_EN
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
`endif
    if (game_start_i) begin
      state_d = PLAY;
      level_d = start_level_i;
      acc_d   = 4'd0;
      total_d = 10'd0;
`ifdef LEVEL_FLASH_EN
      fcnt_d  = 8'd0;
      phase_d = 1'b0;
`endif
    end else if (game_over_i) begin
      state_d = IDLE;
`ifdef LEVEL_FLASH_EN
      phase_d = 1'b0;
`endif
    end else if (state_q != IDLE && clear_valid_i) begin
      total_d = (tsum > 11'd999) ? 10'd999 : tsum[9:0];
      acc_d   = lvl_step ? 4'(sum - 5'(LINES_PER_LEVEL)) : sum[3:0];
      level_d = lvl_step ? level_q + 3'd1 : level_q;
      up_d    = lvl_step;
`ifdef LEVEL_FLASH_EN
      if (lvl_step) begin
        state_d = FLASH;
        fcnt_d  = 8'd0;
        phase_d = 1'b0;
      end
    end else if (state_q == FLASH && frame_tick_i) begin
      state_d = (fcnt_q == 8'(FLASH_FRAMES - 1)) ? PLAY : FLASH;
      phase_d = (fcnt_q == 8'(FLASH_FRAMES - 1)) ? 1'b0 : ~phase_q;
      fcnt_d  = fcnt_q + 8'd1;
`endif
    end
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      level_q <= 3'd0;
      acc_q   <= 4'd0;
      total_q <= 10'd0;
      up_q    <= 1'b0;
`ifdef LEVEL_FLASH_EN
      fcnt_q  <= 8'd0;
      phase_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      acc_q   <= acc_d;
      total_q <= total_d;
      up_q    <= up_d;
`ifdef LEVEL_FLASH_EN
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
`endif
    end
  end
  assign level_o       = level_q;
  assign level_up_o    = up_q;
  assign line_acc_o    = acc_q;
  assign lines_total_o = total_q;
endmodule

// File: tb/tb_level_palette_ctrl.sv
// tb_level_palette_ctrl: directed checks of the level sequencer (flash checks when LEVEL_FLASH_EN is defined)
module tb_level_palette_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0, game_start = 1'b0, game_over = 1'b0, frame_tick = 1'b0, clear_valid = 1'b0;
  logic [2:0] start_level = 3'd0, clear_count = 3'd0;
  logic [2:0] level;
  logic       level_up, flash_active, flash_phase;
  logic [3:0] line_acc;
  logic [9:0] lines_total;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  level_palette_ctrl dut (
    .clk_i(clk), .reset_n_i(reset_n), .game_start_i(game_start), .game_over_i(game_over),
    .start_level_i(start_level), .frame_tick_i(frame_tick), .clear_valid_i(clear_valid),
    .clear_count_i(clear_count), .level_o(level), .level_up_o(level_up), .line_acc_o(line_acc),
    .lines_total_o(lines_total), .flash_active_o(flash_active), .flash_phase_o(flash_phase)
  );
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr(input logic [2:0] n);
    clear_valid = 1'b1;
    clear_count = n;
    tick();
    clear_valid = 1'b0;
    clear_count = 3'd0;
  endtask
  task automatic ftick();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
  endtask
  initial begin
    tick(); tick();
    reset_n = 1'b1;
    check("rst_level", level, 0);
    check("rst_acc", line_acc, 0);
    check("rst_total", lines_total, 0);
    check("rst_up", level_up, 0);
    check("rst_active", flash_active, 0);
    check("rst_phase", flash_phase, 0);
    clr(3'd4);
    check("idle_level", level, 0);
    check("idle_acc", line_acc, 0);
    check("idle_total", lines_total, 0);
    check("idle_up", level_up, 0);
    start_level = 3'd3;
    game_start = 1'b1;
    tick();
    game_start = 1'b0;
    check("start_level", level, 3);
    check("start_acc", line_acc, 0);
    clr(3'd4);
    check("c1_acc", line_acc, 4);
    check("c1_total", lines_total, 4);
    clr(3'd4);
    check("c2_acc", line_acc, 8);
    check("c2_up", level_up, 0);
    clr(3'd2);
    check("lu_level", level, 4);
    check("lu_up", level_up, 1);
    check("lu_acc", line_acc, 0);
    check("lu_total", lines_total, 10);
`ifdef LEVEL_FLASH_EN
    check("lu_active", flash_active, 1);
    check("lu_phase", flash_phase, 0);
`else
    check("lu_active", flash_active, 0);
`endif
    tick();
    check("lu_up_pulse", level_up, 0);
    for (int i = 1; i <= 3; i++) begin
      ftick();
`ifdef LEVEL_FLASH_EN
      check("fl_phase", flash_phase, i % 2);
`else
      check("fl_phase_off", flash_phase, 0);
`endif
    end
    clr(3'd4);
    clr(3'd4);
    clr(3'd2);
    check("lu2_level", level, 5);
    check("lu2_up", level_up, 1);
    check("lu2_total", lines_total, 20);
`ifdef LEVEL_FLASH_EN
    check("lu2_phase", flash_phase, 0);
    check("lu2_active", flash_active, 1);
    for (int i = 1; i <= 7; i++) begin
      ftick();
      check("fl2_phase", flash_phase, i % 2);
      check("fl2_active", flash_active, 1);
    end
    ftick();
    check("fl_end_active", flash_active, 0);
    check("fl_end_phase", flash_phase, 0);
`else
    check("lu2_active", flash_active, 0);
`endif
    for (int i = 0; i < 5; i++) clr(3'd4);
    check("w_level7", level, 7);
    clr(3'd4);
    clr(3'd4);
    check("w_acc8", line_acc, 8);
    clr(3'd3);
    check("wrap_level", level, 0);
    check("wrap_acc", line_acc, 1);
    check("wrap_up", level_up, 1);
    check("wrap_total", lines_total, 51);
    clr(3'd7);
    check("sat7_acc", line_acc, 5);
    check("sat7_total", lines_total, 55);
    clr(3'd0);
    check("zero_acc", line_acc, 5);
    check("zero_total", lines_total, 55);
    check("zero_up", level_up, 0);
`ifdef LEVEL_FLASH_EN
    check("pre_over_active", flash_active, 1);
`endif
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    check("over_active", flash_active, 0);
    check("over_phase", flash_phase, 0);
    check("over_level", level, 0);
    clr(3'd4);
    check("over_acc", line_acc, 5);
    check("over_total", lines_total, 55);
    start_level = 3'd6;
    game_start = 1'b1;
    clear_valid = 1'b1;
    clear_count = 3'd4;
    tick();
    game_start = 1'b0;
    clear_valid = 1'b0;
    clear_count = 3'd0;
    check("sc_level", level, 6);
    check("sc_acc", line_acc, 0);
    check("sc_total", lines_total, 0);
    check("sc_up", level_up, 0);
    for (int i = 0; i < 249; i++) clr(3'd4);
    clr(3'd2);
    check("t998_total", lines_total, 998);
    check("t998_level", level, 1);
    check("t998_acc", line_acc, 8);
    clr(3'd4);
    check("t999_total", lines_total, 999);
    check("t999_level", level, 2);
    clr(3'd4);
    check("t999_hold", lines_total, 999);
    check("t999_acc", line_acc, 6);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rst2_level", level, 0);
    check("rst2_total", lines_total, 0);
    check("rst2_active", flash_active, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
